// File: rtl/matrix_line_ram.sv
// N x N element store: single-element writes, full row/column reads with an
// optional upper-triangular mask, a row-per-cycle bulk clear and error strobes.
module matrix_line_ram #(
    parameter int unsigned DATA_W = 19,
    parameter int unsigned N      = 8,
    parameter int unsigned IDX_W  = 3
) (
    input  logic                CK,
    input  logic                RST_N,
    input  logic                CLR,
    output logic                BUSY,
    input  logic                WE,
    input  logic [IDX_W-1:0]    W_ROW,
    input  logic [IDX_W-1:0]    W_COL,
    input  logic [DATA_W-1:0]   D,
    input  logic                RE,
    input  logic [IDX_W-1:0]    R_IDX,
    input  logic                R_COL,
    input  logic                TRI_MASK,
    output logic [N*DATA_W-1:0] Q,
    output logic                Q_VALID,
    output logic                Q_ERR
);

    localparam int unsigned LINE_W = N * DATA_W;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    state_e              state_q;
    logic [IDX_W-1:0]    clr_cnt_q;
    logic                busy_q;
    logic [LINE_W-1:0]   q_q;
    logic                q_valid_q;
    logic                q_err_q;

    logic [DATA_W-1:0]   mem_q [N][N];

    logic                idle_c;
    logic                wr_ok_c;
    logic                rd_acc_c;
    logic                rd_ok_c;
    logic [IDX_W-1:0]    rd_idx_safe_c;
    logic [LINE_W-1:0]   line_c;

    // Request qualification: CLR pre-empts writes/reads, bad indices never touch memory
    always_comb begin
        idle_c        = (state_q == ST_IDLE);
        wr_ok_c       = idle_c && WE && !CLR
                        && (32'(W_ROW) < N) && (32'(W_COL) < N);
        rd_acc_c      = idle_c && RE && !CLR;
        rd_ok_c       = (32'(R_IDX) < N);
        rd_idx_safe_c = rd_ok_c ? R_IDX : '0;
    end

    // Gather the requested row or column, masking below-diagonal sources when asked
    always_comb begin
        logic [IDX_W-1:0] src_r;
        logic [IDX_W-1:0] src_c;
        line_c = '0;
        src_r  = '0;
        src_c  = '0;
        for (int i = 0; i < N; i++) begin
            src_r = R_COL ? IDX_W'(i) : rd_idx_safe_c;
            src_c = R_COL ? rd_idx_safe_c : IDX_W'(i);
            if (rd_ok_c && !(TRI_MASK && (src_r > src_c))) begin
                line_c[DATA_W*i +: DATA_W] = mem_q[src_r][src_c];
            end
        end
    end

    // Element storage (not reset): one row zeroed per clear cycle, else single writes
    always_ff @(posedge CK) begin
        if (state_q == ST_CLEAR) begin
            for (int c = 0; c < N; c++) begin
                mem_q[clr_cnt_q][c] <= '0;
            end
        end else if (wr_ok_c) begin
            mem_q[W_ROW][W_COL] <= D;
        end
    end

    // Control FSM with registered read line, strobes and busy flag
    always_ff @(posedge CK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= ST_IDLE;
            clr_cnt_q <= '0;
            busy_q    <= 1'b0;
            q_q       <= '0;
            q_valid_q <= 1'b0;
            q_err_q   <= 1'b0;
        end else begin
            q_valid_q <= 1'b0;
            q_err_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (CLR) begin
                        state_q   <= ST_CLEAR;
                        clr_cnt_q <= '0;
                        busy_q    <= 1'b1;
                    end else if (rd_acc_c) begin
                        q_q       <= line_c;
                        q_valid_q <= 1'b1;
                        q_err_q   <= !rd_ok_c;
                    end
                end
                ST_CLEAR: begin
                    if (clr_cnt_q == IDX_W'(N - 1)) begin
                        state_q   <= ST_IDLE;
                        clr_cnt_q <= '0;
                        busy_q    <= 1'b0;
                    end else begin
                        clr_cnt_q <= clr_cnt_q + IDX_W'(1);
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    clr_cnt_q <= '0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign BUSY    = busy_q;
    assign Q       = q_q;
    assign Q_VALID = q_valid_q;
    assign Q_ERR   = q_err_q;

endmodule

// File: tb/tb_matrix_line_ram.sv
// Bench for matrix_line_ram: an N=8 instance checked every cycle against a
// behavioural matrix model plus literal checks, and an N=6 instance for range errors.
module tb_matrix_line_ram;

    localparam int unsigned DW = 19;
    localparam int unsigned N8 = 8;
    localparam int unsigned N6 = 6;
    localparam int unsigned IW = 3;

    logic ck = 1'b0;
    logic rst_n = 1'b0;
    always #5 ck = ~ck;

    // N=8 instance signals
    logic            clr = 0, we = 0, re = 0, r_col = 0, tri_m = 0;
    logic [IW-1:0]   w_row = 0, w_col = 0, r_idx = 0;
    logic [DW-1:0]   d = 0;
    logic            busy, q_valid, q_err;
    logic [N8*DW-1:0] q;

    // N=6 instance signals
    logic            clr6 = 0, we6 = 0, re6 = 0, r_col6 = 0, tri_m6 = 0;
    logic [IW-1:0]   w_row6 = 0, w_col6 = 0, r_idx6 = 0;
    logic [DW-1:0]   d6 = 0;
    logic            busy6, q_valid6, q_err6;
    logic [N6*DW-1:0] q6;

    matrix_line_ram #(.DATA_W(DW), .N(N8), .IDX_W(IW)) u8 (
        .CK(ck), .RST_N(rst_n), .CLR(clr), .BUSY(busy),
        .WE(we), .W_ROW(w_row), .W_COL(w_col), .D(d),
        .RE(re), .R_IDX(r_idx), .R_COL(r_col), .TRI_MASK(tri_m),
        .Q(q), .Q_VALID(q_valid), .Q_ERR(q_err)
    );

    matrix_line_ram #(.DATA_W(DW), .N(N6), .IDX_W(IW)) u6 (
        .CK(ck), .RST_N(rst_n), .CLR(clr6), .BUSY(busy6),
        .WE(we6), .W_ROW(w_row6), .W_COL(w_col6), .D(d6),
        .RE(re6), .R_IDX(r_idx6), .R_COL(r_col6), .TRI_MASK(tri_m6),
        .Q(q6), .Q_VALID(q_valid6), .Q_ERR(q_err6)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic int el8(input int i);
        return int'(q[i*DW +: DW]);
    endfunction

    function automatic int el6(input int i);
        return int'(q6[i*DW +: DW]);
    endfunction

    // ---------------- behavioural model of the N=8 instance ----------------
    int mm [N8][N8];
    int exp_q [N8];
    bit exp_valid = 0, exp_err = 0, exp_busy = 0;
    int clr_left = 0;

    always @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            exp_valid <= 0;
            exp_err   <= 0;
            exp_busy  <= 0;
            clr_left  <= 0;
            for (int i = 0; i < N8; i++) exp_q[i] <= 0;
        end else if (clr_left > 0) begin
            clr_left  <= clr_left - 1;
            exp_busy  <= (clr_left > 1);
            exp_valid <= 0;
            exp_err   <= 0;
        end else if (clr) begin
            clr_left  <= N8;
            exp_busy  <= 1;
            exp_valid <= 0;
            exp_err   <= 0;
            for (int r = 0; r < N8; r++)
                for (int c = 0; c < N8; c++) mm[r][c] <= 0;
        end else begin
            exp_busy  <= 0;
            exp_valid <= re;
            exp_err   <= 0;
            if (re) begin
                for (int i = 0; i < N8; i++) begin
                    int sr, sc;
                    sr = r_col ? i : int'(r_idx);
                    sc = r_col ? int'(r_idx) : i;
                    exp_q[i] <= (tri_m && sr > sc) ? 0 : mm[sr][sc];
                end
            end
            if (we) mm[w_row][w_col] <= int'(d);
        end
    end

    // Per-cycle comparison of every N=8 output against the model
    always @(negedge ck) begin
        logic [N8*DW-1:0] ev;
        ev = '0;
        for (int i = 0; i < N8; i++) ev[i*DW +: DW] = DW'(exp_q[i]);
        n_tests++;
        if (q !== ev) begin
            n_fail++;
            $display("FAIL model_q: got %h, expected %h (t=%0t)", q, ev, $time);
        end
        check("model_valid", longint'(q_valid), longint'(exp_valid));
        check("model_err", longint'(q_err), longint'(exp_err));
        check("model_busy", longint'(busy), longint'(exp_busy));
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge ck);
        #1;
    endtask

    task automatic wr8(input int r, input int c, input int v);
        we = 1; w_row = IW'(r); w_col = IW'(c); d = DW'(v);
        cyc();
        we = 0;
    endtask

    task automatic rd8(input int idx, input bit col, input bit tm);
        re = 1; r_idx = IW'(idx); r_col = col; tri_m = tm;
        cyc();
        re = 0; tri_m = 0;
    endtask

    task automatic wr6(input int r, input int c, input int v);
        we6 = 1; w_row6 = IW'(r); w_col6 = IW'(c); d6 = DW'(v);
        cyc();
        we6 = 0;
    endtask

    task automatic rd6(input int idx, input bit col);
        re6 = 1; r_idx6 = IW'(idx); r_col6 = col;
        cyc();
        re6 = 0;
    endtask

    // Hold WE/RE active through the clear and count the BUSY cycles
    task automatic run_clear(input string name);
        int cnt;
        int k;
        cnt = 0;
        k = 0;
        we = 1; w_row = 0; w_col = 0; d = 19'd123;
        re = 1; r_idx = 0; r_col = 0;
        while (busy && k < 20) begin
            cnt++;
            k++;
            check({name, "_valid_in_busy"}, longint'(q_valid), 0);
            cyc();
        end
        we = 0; re = 0;
        check({name, "_busy_cycles"}, cnt, 8);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int row3 [8] = '{48, 49, 50, 51, 52, 53, 54, 55};
        int col3 [8] = '{3, 19, 35, 51, 67, 83, 99, 115};
        int row5t[8] = '{0, 0, 0, 0, 0, 85, 86, 87};
        int col2t[8] = '{2, 18, 34, 0, 0, 0, 0, 0};

        repeat (2) @(posedge ck);
        #1;
        check("reset_busy", longint'(busy), 0);
        check("reset_valid", longint'(q_valid), 0);
        check("reset_err", longint'(q_err), 0);
        check("reset_q_zero", longint'(q == '0), 1);
        rst_n = 1;
        cyc();

        // identity load
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) wr8(r, c, 16*r + c);

        rd8(3, 0, 0);
        check("row3_valid", longint'(q_valid), 1);
        for (int i = 0; i < 8; i++) check("row3_elem", el8(i), row3[i]);
        rd8(3, 1, 0);
        for (int i = 0; i < 8; i++) check("col3_elem", el8(i), col3[i]);
        cyc();
        check("idle_valid_low", longint'(q_valid), 0);
        check("idle_q_holds", el8(7), 115);

        // triangular mask
        rd8(5, 0, 1);
        for (int i = 0; i < 8; i++) check("row5_tri", el8(i), row5t[i]);
        rd8(2, 1, 1);
        for (int i = 0; i < 8; i++) check("col2_tri", el8(i), col2t[i]);

        // back-to-back row then column reads
        re = 1;
        for (int k = 0; k < 16; k++) begin
            r_idx = IW'(k % 8); r_col = (k >= 8); tri_m = k[0];
            cyc();
            check("b2b_valid", longint'(q_valid), 1);
        end
        re = 0; tri_m = 0;

        // read/write collision
        wr8(2, 2, 7);
        we = 1; w_row = 2; w_col = 2; d = 19'd9;
        re = 1; r_idx = 2; r_col = 0;
        cyc();
        we = 0; re = 0;
        check("collide_old", el8(2), 7);
        rd8(2, 0, 0);
        check("collide_new", el8(2), 9);

        // bulk clear
        clr = 1;
        cyc();
        clr = 0;
        run_clear("clear1");
        check("after_clear_q_holds", el8(2), 9);
        for (int r = 0; r < 8; r++) rd8(r, 0, 0);
        for (int c = 0; c < 8; c++) rd8(c, 1, 0);
        check("clear_write_dropped", el8(0), 0);
        check("clear_all_zero", longint'(q == '0), 1);

        // CLR wins over simultaneous WE/RE
        clr = 1; we = 1; w_row = 1; w_col = 1; d = 19'd77; re = 1; r_idx = 1;
        cyc();
        clr = 0; we = 0; re = 0;
        check("clr_wins_no_valid", longint'(q_valid), 0);
        run_clear("clear2");
        rd8(1, 0, 0);
        check("clr_wins_write_dropped", el8(1), 0);

        // async reset mid-clear
        wr8(1, 1, 5);
        rd8(1, 0, 0);
        check("pre_reset_q", el8(1), 5);
        clr = 1;
        cyc();
        clr = 0;
        cyc();
        cyc();
        #2 rst_n = 0;
        #1;
        check("async_busy", longint'(busy), 0);
        check("async_valid", longint'(q_valid), 0);
        check("async_err", longint'(q_err), 0);
        check("async_q_zero", longint'(q == '0), 1);
        cyc();
        rst_n = 1;
        cyc();
        clr = 1;
        cyc();
        clr = 0;
        run_clear("clear_after_reset");
        rd8(1, 0, 0);
        check("post_reset_clear_zero", longint'(q == '0), 1);

        // N=6 instance: out-of-range reads and writes
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 6; c++) wr6(r, c, 16*r + c);
        rd6(7, 0);
        check("n6_oor_valid", longint'(q_valid6), 1);
        check("n6_oor_err", longint'(q_err6), 1);
        check("n6_oor_q_zero", longint'(q6 == '0), 1);
        cyc();
        check("n6_err_strobe", longint'(q_err6), 0);
        check("n6_valid_strobe", longint'(q_valid6), 0);
        rd6(6, 1);
        check("n6_oor6_err", longint'(q_err6), 1);
        check("n6_oor6_q_zero", longint'(q6 == '0), 1);
        rd6(5, 0);
        check("n6_row5_err", longint'(q_err6), 0);
        for (int i = 0; i < 6; i++) check("n6_row5_elem", el6(i), 80 + i);
        wr6(6, 0, 19'h7FFFF);
        wr6(0, 6, 19'h7FFFF);
        wr6(7, 7, 19'h7FFFF);
        for (int r = 0; r < 6; r++) begin
            rd6(r, 0);
            for (int i = 0; i < 6; i++) check("n6_no_alias", el6(i), 16*r + i);
        end
        rd6(0, 1);
        for (int i = 0; i < 6; i++) check("n6_col0", el6(i), 16*i);

        cyc();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
